bus_encoder_arb: RTL and testbench

BUS_ENCODER_ARB -- requirements
Module: bus_encoder_arb

---
 rtl/bus_encoder_arb.sv | 100 ++++++++++
 tb/tb_bus_encoder_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_encoder_arb.sv
// rtl/bus_encoder_arb.sv - request vector encoder: strict one-hot, fixed priority or round-robin
// Registered result with valid/ready handshake, none/multi flags and a strict-mode error counter.
module bus_encoder_arb #(
   parameter int N = 32,
   parameter int W = 5,
   parameter int MODE = 0,
   parameter logic [W-1:0] DEFAULT_CODE = '1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] in_req,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_code,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_none,
   output logic         out_multi,
   output logic [7:0]   err_count
);

   logic [W-1:0] ptr;
   logic [W-1:0] ptr_next;
   logic [6:0]   pop;
   logic [W-1:0] low_code;
   logic [W-1:0] rr_code;
   logic [W-1:0] sel_code;
   logic [N-1:0] rot;
   logic [W:0]   rr_sum;
   logic         accept;
   logic         none_c;
   logic         multi_c;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      pop      = '0;
      low_code = DEFAULT_CODE;
      rr_code  = DEFAULT_CODE;
      rr_sum   = '0;
      sel_code = DEFAULT_CODE;
      ptr_next = '0;
      // rotate so bit 0 of rot is the request at ptr; doubling handles the wrap
      rot = N'({in_req, in_req} >> ptr);

      for (int i = 0; i < N; i++)
         pop = pop + 7'(in_req[i]);

      for (int i = N - 1; i >= 0; i--)
         if (in_req[i])
            low_code = W'(i);

      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            rr_sum = {1'b0, ptr} + (W+1)'(k);
            if (rr_sum >= (W+1)'(N))
               rr_sum = rr_sum - (W+1)'(N);
            rr_code = rr_sum[W-1:0];
         end
      end

      none_c  = (pop == 7'd0);
      multi_c = (pop >= 7'd2);

      if (MODE == 0)
         sel_code = (pop == 7'd1) ? low_code : DEFAULT_CODE;
      else if (MODE == 1)
         sel_code = low_code;
      else
         sel_code = rr_code;

      ptr_next = (rr_code == W'(N - 1)) ? '0 : rr_code + W'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         out_valid <= 1'b0;
         out_code  <= DEFAULT_CODE;
         out_none  <= 1'b0;
         out_multi <= 1'b0;
         err_count <= 8'd0;
         ptr       <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_code  <= sel_code;
            out_none  <= none_c;
            out_multi <= multi_c;
            if (MODE == 2 && !none_c)
               ptr <= ptr_next;
            if (MODE == 0 && (none_c || multi_c) && err_count != 8'hFF)
               err_count <= err_count + 8'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bus_encoder_arb.sv
// tb/tb_bus_encoder_arb.sv - bench for bus_encoder_arb in all three modes
// Three instances share handshake and reset; a vector-level model checks every cycle.
module tb_bus_encoder_arb;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] req32;
   logic [4:0]  req5;

   logic        rdy0, rdy1, rdy2;
   logic        v0, v1, v2;
   logic [4:0]  code0, code1;
   logic [2:0]  code2;
   logic        none0, none1, none2;
   logic        multi0, multi1, multi2;
   logic [7:0]  err0, err1, err2;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   int m_valid, m_code0, m_code1, m_code2;
   int m_none32, m_multi32, m_none5, m_multi5;
   int m_err, m_ptr;

   always #5 clk = ~clk;

   bus_encoder_arb #(.N(32), .W(5), .MODE(0)) u0 (
      .clk(clk), .clr(clr), .in_req(req32), .in_valid(in_valid), .in_ready(rdy0),
      .out_code(code0), .out_valid(v0), .out_ready(out_ready),
      .out_none(none0), .out_multi(multi0), .err_count(err0));

   bus_encoder_arb #(.N(32), .W(5), .MODE(1)) u1 (
      .clk(clk), .clr(clr), .in_req(req32), .in_valid(in_valid), .in_ready(rdy1),
      .out_code(code1), .out_valid(v1), .out_ready(out_ready),
      .out_none(none1), .out_multi(multi1), .err_count(err1));

   bus_encoder_arb #(.N(5), .W(3), .MODE(2)) u2 (
      .clk(clk), .clr(clr), .in_req(req5), .in_valid(in_valid), .in_ready(rdy2),
      .out_code(code2), .out_valid(v2), .out_ready(out_ready),
      .out_none(none2), .out_multi(multi2), .err_count(err2));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int popc(input logic [31:0] v, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic int lowest(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int rr_pick(input logic [4:0] v, input int p);
      for (int k = 0; k < 5; k++) if (v[(p + k) % 5]) return (p + k) % 5;
      return -1;
   endfunction

   // reference model: state after each edge, from the encoding rules directly
   always @(posedge clk) begin
      if (clr) begin
         m_valid <= 0; m_code0 <= 31; m_code1 <= 31; m_code2 <= 7;
         m_none32 <= 0; m_multi32 <= 0; m_none5 <= 0; m_multi5 <= 0;
         m_err <= 0; m_ptr <= 0;
      end else if (in_valid && (m_valid == 0 || out_ready)) begin
         int p32, p5, w;
         p32 = popc(req32, 32);
         p5  = popc({27'd0, req5}, 5);
         w   = rr_pick(req5, m_ptr);
         m_valid   <= 1;
         m_code0   <= (p32 == 1) ? lowest(req32, 32) : 31;
         m_code1   <= (p32 == 0) ? 31 : lowest(req32, 32);
         m_code2   <= (w < 0) ? 7 : w;
         m_none32  <= int'(p32 == 0);
         m_multi32 <= int'(p32 >= 2);
         m_none5   <= int'(p5 == 0);
         m_multi5  <= int'(p5 >= 2);
         if (w >= 0) m_ptr <= (w + 1) % 5;
         if (p32 != 1 && m_err < 255) m_err <= m_err + 1;
      end else if (out_ready) begin
         m_valid <= 0;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready0", int'(rdy0), int'(m_valid == 0 || out_ready));
         chk("in_ready2", int'(rdy2), int'(m_valid == 0 || out_ready));
         chk("out_valid0", int'(v0), m_valid);
         chk("out_valid1", int'(v1), m_valid);
         chk("out_valid2", int'(v2), m_valid);
         chk("err_count0", int'(err0), m_err);
         chk("err_count1", int'(err1), 0);
         chk("err_count2", int'(err2), 0);
         if (m_valid != 0) begin
            chk("out_code0", int'(code0), m_code0);
            chk("out_code1", int'(code1), m_code1);
            chk("out_code2", int'(code2), m_code2);
            chk("out_none0", int'(none0), m_none32);
            chk("out_multi1", int'(multi1), m_multi32);
            chk("out_none2", int'(none2), m_none5);
            chk("out_multi2", int'(multi2), m_multi5);
         end
      end
   end

   task automatic cyc(input logic [31:0] r32, input logic [4:0] r5,
                      input logic iv, input logic ordy);
      req32     = r32;
      req5      = r5;
      in_valid  = iv;
      out_ready = ordy;
      @(posedge clk);
      #2;
   endtask

   initial begin
      clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1; req32 = '0; req5 = '0;
      @(posedge clk);
      #2;
      clr   = 1'b0;
      armed = 1'b1;
      chk("reset_valid", int'(v0), 0);
      chk("reset_code", int'(code0), 31);
      chk("reset_err", int'(err0), 0);
      chk("reset_ready", int'(rdy0), 1);

      cyc(32'h0000_0400, 5'b0, 1'b1, 1'b1);
      chk("onehot_code", int'(code0), 10);
      chk("onehot_valid", int'(v0), 1);
      chk("onehot_none", int'(none0), 0);
      chk("onehot_multi", int'(multi0), 0);

      cyc(32'h0000_0006, 5'b0, 1'b1, 1'b1);
      chk("multi_code", int'(code0), 31);
      chk("multi_flag", int'(multi0), 1);
      chk("prio_code_6", int'(code1), 1);
      cyc(32'h0, 5'b0, 1'b1, 1'b1);
      chk("zero_code", int'(code0), 31);
      chk("zero_none", int'(none0), 1);
      chk("err_after_two", int'(err0), 2);

      cyc(32'h8000_0030, 5'b0, 1'b1, 1'b1);
      chk("prio_code", int'(code1), 4);
      chk("prio_multi", int'(multi1), 1);
      chk("prio_err", int'(err1), 0);

      cyc(32'h0, 5'b10011, 1'b1, 1'b1);
      chk("rr_0", int'(code2), 0);
      cyc(32'h0, 5'b10011, 1'b1, 1'b1);
      chk("rr_1", int'(code2), 1);
      cyc(32'h0, 5'b10011, 1'b1, 1'b1);
      chk("rr_2", int'(code2), 4);
      cyc(32'h0, 5'b10011, 1'b1, 1'b1);
      chk("rr_3_wrap", int'(code2), 0);
      chk("err_seven", int'(err0), 7);

      cyc(32'h1, 5'b00100, 1'b1, 1'b0);
      chk("bp_ready", int'(rdy0), 0);
      chk("bp_valid", int'(v0), 1);
      chk("bp_hold0", int'(code0), 31);
      chk("bp_hold2", int'(code2), 0);
      cyc(32'h1, 5'b00100, 1'b1, 1'b1);
      chk("bp_release0", int'(code0), 0);
      chk("bp_release2", int'(code2), 2);
      chk("bp_err", int'(err0), 7);

      cyc(32'h1, 5'b00100, 1'b0, 1'b1);
      chk("drain_valid", int'(v0), 0);
      chk("drain_hold", int'(code0), 0);

      cyc(32'h0, 5'b11111, 1'b1, 1'b1);
      chk("pre_clr_err", int'(err0), 8);
      clr = 1'b1;
      cyc(32'h0, 5'b11111, 1'b1, 1'b1);
      clr = 1'b0;
      chk("clr_valid", int'(v0), 0);
      chk("clr_err", int'(err0), 0);
      chk("clr_code2", int'(code2), 7);
      chk("clr_ready", int'(rdy2), 1);
      cyc(32'h0, 5'b11111, 1'b1, 1'b1);
      chk("clr_ptr", int'(code2), 0);

      for (int i = 0; i < 80; i++) begin
         logic [31:0] r;
         r = 32'h1 << $urandom_range(31, 0);
         if ($urandom_range(3, 0) == 0) r = $urandom;
         if ($urandom_range(7, 0) == 0) r = 32'h0;
         cyc(r, 5'($urandom), 1'($urandom_range(3, 0) != 0), 1'($urandom_range(2, 0) != 0));
      end

      for (int i = 0; i < 270; i++)
         cyc(32'h0, 5'b0, 1'b1, 1'b1);
      chk("err_saturate", int'(err0), 255);

      @(negedge clk);
      armed = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
